// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between icache and dcache miss paths
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 128,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  icache_req_valid,
  input  logic [ADDR_WIDTH-1:0] icache_req_addr,
  output logic                  icache_rsp_valid,
  output logic [LINE_WIDTH-1:0] icache_rsp_data,
  input  logic                  dcache_req_valid,
  input  logic [ADDR_WIDTH-1:0] dcache_req_addr,
  input  logic                  dcache_req_is_store,
  input  logic [LINE_WIDTH-1:0] dcache_req_data,
  output logic                  dcache_rsp_valid,
  output logic [LINE_WIDTH-1:0] dcache_rsp_data,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_is_store,
  output logic [LINE_WIDTH-1:0] mem_req_data,
  input  logic                  mem_rsp_valid,
  input  logic [LINE_WIDTH-1:0] mem_rsp_data,
  output logic                  mem_timeout
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  st_q, st_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  mreq_q, mreq_d;
  logic                  irv_q, irv_d;
  logic                  drv_q, drv_d;
  logic [LINE_WIDTH-1:0] ird_q, ird_d;
  logic [LINE_WIDTH-1:0] drd_q, drd_d;
  logic                  to_q, to_d;
  logic                  gnt;
  logic                  fin;
  logic [LINE_WIDTH-1:0] rdata;
  assign icache_rsp_valid = irv_q;
  assign icache_rsp_data  = ird_q;
  assign dcache_rsp_valid = drv_q;
  assign dcache_rsp_data  = drd_q;
  assign mem_req_valid    = mreq_q;
  assign mem_req_addr     = addr_q;
  assign mem_req_is_store = st_q;
  assign mem_req_data     = wdata_q;
  assign mem_timeout      = to_q;
  // Next-state and registered-output computation; owner 1 = dcache, 0 = icache
  always_comb begin
    gnt     = dcache_req_valid && (!icache_req_valid || !last_q);
    fin     = mem_rsp_valid || cnt_q == CW'(MEM_TIMEOUT - 1);
    rdata   = (mem_rsp_valid && !st_q) ? mem_rsp_data : '0;
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    st_d    = st_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    mreq_d  = 1'b0;
    irv_d   = 1'b0;
    drv_d   = 1'b0;
    ird_d   = ird_q;
    drd_d   = drd_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: if (icache_req_valid || dcache_req_valid) begin
        owner_d = gnt;
        last_d  = gnt;
        addr_d  = gnt ? dcache_req_addr : icache_req_addr;
        st_d    = gnt && dcache_req_is_store;
        wdata_d = gnt ? dcache_req_data : '0;
        mreq_d  = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (fin) begin
          state_d = RESP;
          to_d    = !mem_rsp_valid;
          irv_d   = !owner_q;
          drv_d   = owner_q;
          ird_d   = owner_q ? ird_q : rdata;
          drd_d   = owner_q ? rdata : drd_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      st_q    <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      mreq_q  <= 1'b0;
      irv_q   <= 1'b0;
      drv_q   <= 1'b0;
      ird_q   <= '0;
      drd_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      st_q    <= st_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      mreq_q  <= mreq_d;
      irv_q   <= irv_d;
      drv_q   <= drv_d;
      ird_q   <= ird_d;
      drd_q   <= drd_d;
      to_q    <= to_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with directed vectors
module tb_mem_arbiter;
  logic         clock = 1'b0;
  logic         reset;
  logic         icache_req_valid;
  logic [31:0]  icache_req_addr;
  logic         icache_rsp_valid;
  logic [127:0] icache_rsp_data;
  logic         dcache_req_valid;
  logic [31:0]  dcache_req_addr;
  logic         dcache_req_is_store;
  logic [127:0] dcache_req_data;
  logic         dcache_rsp_valid;
  logic [127:0] dcache_rsp_data;
  logic         mem_req_valid;
  logic [31:0]  mem_req_addr;
  logic         mem_req_is_store;
  logic [127:0] mem_req_data;
  logic         mem_rsp_valid;
  logic [127:0] mem_rsp_data;
  logic         mem_timeout;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  typedef struct {logic [31:0] addr; logic st; logic [127:0] data; int c;} req_t;
  typedef struct {logic d; logic [127:0] data; logic to; int c;} rsp_t;
  req_t rq[$];
  rsp_t sq[$];
  localparam logic [127:0] DB = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

  mem_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(128), .MEM_TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .icache_req_valid(icache_req_valid), .icache_req_addr(icache_req_addr),
    .icache_rsp_valid(icache_rsp_valid), .icache_rsp_data(icache_rsp_data),
    .dcache_req_valid(dcache_req_valid), .dcache_req_addr(dcache_req_addr),
    .dcache_req_is_store(dcache_req_is_store), .dcache_req_data(dcache_req_data),
    .dcache_rsp_valid(dcache_rsp_valid), .dcache_rsp_data(dcache_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_is_store(mem_req_is_store), .mem_req_data(mem_req_data),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_timeout(mem_timeout)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic push_req(input logic [31:0] a, input logic s, input logic [127:0] d, input int c);
    req_t r;
    r.addr = a; r.st = s; r.data = d; r.c = c;
    rq.push_back(r);
  endtask

  task automatic push_rsp(input logic d, input logic [127:0] x, input logic t, input int c);
    rsp_t r;
    r.d = d; r.data = x; r.to = t; r.c = c;
    sq.push_back(r);
  endtask

  task automatic mem_pulse(input int c, input logic [127:0] d);
    wait_to(c);
    mem_rsp_valid = 1'b1;
    mem_rsp_data = d;
    wait_to(c + 1);
    mem_rsp_valid = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT presents a request or response
  always @(negedge clock) begin
    req_t e;
    rsp_t s;
    if (mem_req_valid) begin
      if (rq.size() == 0) chk("unexpected_mem_req", mem_req_addr, 128'h0 - 1);
      else begin
        e = rq.pop_front();
        chk("req_cycle", cyc, e.c);
        chk("req_addr", mem_req_addr, e.addr);
        chk("req_is_store", mem_req_is_store, e.st);
        chk("req_data", mem_req_data, e.data);
      end
    end
    if (icache_rsp_valid || dcache_rsp_valid) begin
      if (sq.size() == 0) chk("unexpected_rsp", {icache_rsp_valid, dcache_rsp_valid}, 0);
      else begin
        s = sq.pop_front();
        chk("rsp_cycle", cyc, s.c);
        chk("rsp_owner_i", icache_rsp_valid, !s.d);
        chk("rsp_owner_d", dcache_rsp_valid, s.d);
        chk("rsp_data", s.d ? dcache_rsp_data : icache_rsp_data, s.data);
        chk("rsp_timeout", mem_timeout, s.to);
      end
    end else if (mem_timeout) chk("timeout_without_rsp", mem_timeout, 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int b;
    reset = 1'b1;
    icache_req_valid = 0; icache_req_addr = 0;
    dcache_req_valid = 0; dcache_req_addr = 0;
    dcache_req_is_store = 0; dcache_req_data = 0;
    mem_rsp_valid = 0; mem_rsp_data = 0;
    wait_to(3);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_req_addr", mem_req_addr, 0);
    chk("rst_mem_req_is_store", mem_req_is_store, 0);
    chk("rst_mem_req_data", mem_req_data, 0);
    chk("rst_i_rsp_valid", icache_rsp_valid, 0);
    chk("rst_d_rsp_valid", dcache_rsp_valid, 0);
    chk("rst_i_rsp_data", icache_rsp_data, 0);
    chk("rst_d_rsp_data", dcache_rsp_data, 0);
    chk("rst_timeout", mem_timeout, 0);
    reset = 1'b0;
    // Tie after reset: dcache first, icache two cycles after dcache RESP
    b = 5;
    wait_to(b);
    icache_req_valid = 1; icache_req_addr = 32'h100;
    dcache_req_valid = 1; dcache_req_addr = 32'h200;
    push_req(32'h200, 0, 0, b + 1);
    push_rsp(1, 128'hA, 0, b + 4);
    mem_pulse(b + 3, 128'hA);
    wait_to(b + 4);
    dcache_req_valid = 0;
    push_req(32'h100, 0, 0, b + 6);
    push_rsp(0, 128'hB, 0, b + 9);
    mem_pulse(b + 8, 128'hB);
    wait_to(b + 9);
    icache_req_valid = 0;
    // Single icache miss
    b = 16;
    wait_to(b);
    icache_req_valid = 1; icache_req_addr = 32'h0000_1000;
    push_req(32'h1000, 0, 0, b + 1);
    push_rsp(0, DB, 0, b + 6);
    mem_pulse(b + 5, DB);
    wait_to(b + 6);
    icache_req_valid = 0;
    // Round-robin with both requesting continuously: D I D I D I
    b = 24;
    wait_to(b);
    icache_req_valid = 1; icache_req_addr = 32'h400;
    dcache_req_valid = 1; dcache_req_addr = 32'h500;
    for (int k = 0; k < 6; k++) begin
      push_req((k % 2 == 0) ? 32'h500 : 32'h400, 0, 0, b + 4 * k + 1);
      push_rsp(k % 2 == 0, 128'h1000 + k, 0, b + 4 * k + 3);
      mem_pulse(b + 4 * k + 2, 128'h1000 + k);
    end
    wait_to(b + 23);
    icache_req_valid = 0; dcache_req_valid = 0;
    // Writeback: request fields change after grant and must not leak through
    b = 49;
    wait_to(b);
    dcache_req_valid = 1; dcache_req_addr = 32'h300;
    dcache_req_is_store = 1; dcache_req_data = 128'h1234;
    push_req(32'h300, 1, 128'h1234, b + 1);
    push_rsp(1, 0, 0, b + 5);
    wait_to(b + 2);
    dcache_req_addr = 32'hBAD; dcache_req_data = 128'h5555;
    wait_to(b + 3);
    chk("wait_addr_stable", mem_req_addr, 32'h300);
    chk("wait_data_stable", mem_req_data, 128'h1234);
    chk("wait_store_stable", mem_req_is_store, 1);
    mem_pulse(b + 4, 128'hFFFF);
    wait_to(b + 5);
    dcache_req_valid = 0; dcache_req_is_store = 0; dcache_req_data = 0;
    // Timeout with no response; late response afterwards ignored
    b = 56;
    wait_to(b);
    icache_req_valid = 1; icache_req_addr = 32'h600;
    push_req(32'h600, 0, 0, b + 1);
    push_rsp(0, 0, 1, b + 6);
    wait_to(b + 6);
    icache_req_valid = 0;
    mem_pulse(b + 8, 128'h77);
    wait_to(b + 10);
    chk("late_rsp_i_data_held", icache_rsp_data, 0);
    // Response in the last WAIT cycle wins over the watchdog
    b = 67;
    wait_to(b);
    icache_req_valid = 1; icache_req_addr = 32'h680;
    push_req(32'h680, 0, 0, b + 1);
    push_rsp(0, 128'h99, 0, b + 6);
    mem_pulse(b + 5, 128'h99);
    wait_to(b + 6);
    icache_req_valid = 0;
    // Reset during WAIT drops the transaction and restores last_served
    b = 75;
    wait_to(b);
    dcache_req_valid = 1; dcache_req_addr = 32'h700;
    push_req(32'h700, 0, 0, b + 1);
    wait_to(b + 3);
    reset = 1; dcache_req_valid = 0;
    wait_to(b + 4);
    chk("midrst_mem_req_valid", mem_req_valid, 0);
    chk("midrst_mem_req_addr", mem_req_addr, 0);
    chk("midrst_i_rsp_data", icache_rsp_data, 0);
    chk("midrst_d_rsp_data", dcache_rsp_data, 0);
    reset = 0;
    mem_pulse(b + 5, 128'h42);
    wait_to(b + 7);
    icache_req_valid = 1; icache_req_addr = 32'h800;
    dcache_req_valid = 1; dcache_req_addr = 32'h900;
    push_req(32'h900, 0, 0, b + 8);
    push_rsp(1, 128'hD1, 0, b + 11);
    mem_pulse(b + 10, 128'hD1);
    wait_to(b + 11);
    dcache_req_valid = 0;
    push_req(32'h800, 0, 0, b + 13);
    push_rsp(0, 128'hC1, 0, b + 16);
    mem_pulse(b + 15, 128'hC1);
    wait_to(b + 16);
    icache_req_valid = 0;
    wait_to(b + 22);
    chk("req_queue_drained", rq.size(), 0);
    chk("rsp_queue_drained", sq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
